// File: rtl/imem_sync_if.sv
// Fetch and loader signals between the IF stage / program loader (master) and imem_sync (slave).
// Pure wiring: no latency, no flow control beyond the stall and ld_byte_valid qualifiers.
// AW must equal $clog2(DEPTH) of the attached memory.
interface imem_sync_if #(
    parameter int AW = 8
);
    logic [31:0] pc;
    logic        fetch_req;
    logic        stall;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;
    logic        ld_en;
    logic [7:0]  ld_byte;
    logic        ld_byte_valid;
    logic        ld_busy;
    logic [AW:0] ld_count;
    logic        ld_err;

    modport master (
        output pc, fetch_req, stall, ld_en, ld_byte, ld_byte_valid,
        input  instr, instr_valid, fault, ld_busy, ld_count, ld_err
    );

    modport slave (
        input  pc, fetch_req, stall, ld_en, ld_byte, ld_byte_valid,
        output instr, instr_valid, fault, ld_busy, ld_count, ld_err
    );
endinterface

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory with a byte-serial big-endian program loader.
// Latency: fetch result one edge after pc is sampled; loaded word written on its 4th byte edge.
// Backpressure: stall freezes fetch outputs; loader bytes are accepted only when ld_byte_valid.
module imem_sync #(
    parameter int DEPTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input logic        clk,
    input logic        reset,
    imem_sync_if.slave bus
);
    typedef enum logic {RUN, LOAD} state_t;

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

    state_t      state;
    logic [1:0]  bcnt;
    logic [23:0] asm_hi;
    logic [AW:0] ld_count;
    logic        ld_err;
    logic [31:0] instr;
    logic        instr_valid;
    logic        fault;

    // Programs survive reset, so the array is only zeroed at configuration time.
    logic [31:0] mem [DEPTH] = '{default: '0};

    logic [AW-1:0] rd_idx;
    logic          rd_fault;
    logic          byte_take;
    logic          wr_en;
    logic [31:0]   full_word;

    assign rd_idx    = bus.pc[AW+1:2];
    assign rd_fault  = (bus.pc[1:0] != 2'b00) || (bus.pc[31:AW+2] != '0);
    assign byte_take = (state == LOAD) && bus.ld_en && bus.ld_byte_valid;
    // The 4th byte is never stored; it is merged straight into the write data.
    assign full_word = {asm_hi, bus.ld_byte};
    assign wr_en     = !reset && byte_take && (bcnt == 2'd3) && (ld_count != CNT_FULL);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ld_count[AW-1:0]] <= full_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            bcnt        <= 2'd0;
            asm_hi      <= '0;
            ld_count    <= '0;
            ld_err      <= 1'b0;
            instr       <= '0;
            instr_valid <= 1'b0;
            fault       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.ld_en) begin
                        state       <= LOAD;
                        bcnt        <= 2'd0;
                        asm_hi      <= '0;
                        ld_count    <= '0;
                        ld_err      <= 1'b0;
                        instr       <= '0;
                        instr_valid <= 1'b0;
                        fault       <= 1'b0;
                    end else if (!bus.stall) begin
                        if (bus.fetch_req) begin
                            fault       <= rd_fault;
                            instr       <= rd_fault ? '0 : mem[rd_idx];
                            instr_valid <= 1'b1;
                        end else begin
                            fault       <= 1'b0;
                            instr       <= '0;
                            instr_valid <= 1'b0;
                        end
                    end
                end
                LOAD: begin
                    instr       <= '0;
                    instr_valid <= 1'b0;
                    fault       <= 1'b0;
                    if (!bus.ld_en) begin
                        state <= RUN;
                        bcnt  <= 2'd0;
                        if (bcnt != 2'd0) begin
                            ld_err <= 1'b1;
                        end
                    end else if (bus.ld_byte_valid) begin
                        bcnt <= bcnt + 2'd1;
                        case (bcnt)
                            2'd0: asm_hi[23:16] <= bus.ld_byte;
                            2'd1: asm_hi[15:8]  <= bus.ld_byte;
                            2'd2: asm_hi[7:0]   <= bus.ld_byte;
                            default: begin
                                if (ld_count == CNT_FULL) begin
                                    ld_err <= 1'b1;
                                end else begin
                                    ld_count <= ld_count + CNT_ONE;
                                end
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign bus.instr       = instr;
    assign bus.instr_valid = instr_valid;
    assign bus.fault       = fault;
    assign bus.ld_busy     = (state == LOAD);
    assign bus.ld_count    = ld_count;
    assign bus.ld_err      = ld_err;
endmodule

// File: tb/tb_imem_sync.sv
// Randomized bench for imem_sync against a word-array reference model of loads and fetches.
module tb_imem_sync;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    imem_sync_if #(.AW(AW)) bus();

    imem_sync #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_instr;
    logic        exp_valid;
    logic        exp_fault;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag);
        chk({tag, ".instr"}, bus.instr, exp_instr);
        chk({tag, ".instr_valid"}, 32'(bus.instr_valid), 32'(exp_valid));
        chk({tag, ".fault"}, 32'(bus.fault), 32'(exp_fault));
    endtask

    task automatic fetch(input logic [31:0] pc);
        longint widx;
        bus.pc        = pc;
        bus.fetch_req = 1'b1;
        bus.stall     = 1'b0;
        bus.ld_en     = 1'b0;
        tick();
        widx      = longint'(pc) / 4;
        exp_fault = (pc % 4 != 0) || (widx >= DEPTH);
        exp_valid = 1'b1;
        exp_instr = '0;
        if (!exp_fault) exp_instr = ref_mem[int'(widx)];
        chk_out("fetch");
    endtask

    task automatic idle();
        bus.pc        = $urandom;
        bus.fetch_req = 1'b0;
        bus.stall     = 1'b0;
        tick();
        exp_instr = '0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        chk_out("idle");
    endtask

    task automatic stall_cycles(input int n, input logic [31:0] pc);
        for (int i = 0; i < n; i++) begin
            bus.pc        = pc;
            bus.stall     = 1'b1;
            bus.fetch_req = 1'($urandom_range(0, 1));
            tick();
            chk_out("stall");
        end
        bus.stall = 1'b0;
    endtask

    task automatic do_reset();
        reset             = 1'b1;
        bus.ld_en         = 1'b0;
        bus.ld_byte_valid = 1'($urandom_range(0, 1));
        bus.ld_byte       = 8'($urandom);
        bus.fetch_req     = 1'($urandom_range(0, 1));
        bus.stall         = 1'($urandom_range(0, 1));
        bus.pc            = $urandom;
        tick();
        reset     = 1'b0;
        exp_instr = '0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        chk_out("reset");
        chk("reset.ld_busy", 32'(bus.ld_busy), 32'd0);
        chk("reset.ld_count", 32'(bus.ld_count), 32'd0);
        chk("reset.ld_err", 32'(bus.ld_err), 32'd0);
    endtask

    // One complete session: entry edge (with a junk byte that must be ignored), bytes, exit.
    task automatic load(input logic [7:0] bytes [$], input int gmin, input int gmax);
        int n;
        int words;
        int exp_cnt;
        n = bytes.size();
        bus.ld_en         = 1'b1;
        bus.ld_byte_valid = 1'b1;
        bus.ld_byte       = 8'($urandom);
        bus.fetch_req     = 1'($urandom_range(0, 1));
        bus.stall         = 1'($urandom_range(0, 1));
        tick();
        chk("load.entry.ld_busy", 32'(bus.ld_busy), 32'd1);
        chk("load.entry.ld_count", 32'(bus.ld_count), 32'd0);
        chk("load.entry.ld_err", 32'(bus.ld_err), 32'd0);
        chk("load.entry.instr_valid", 32'(bus.instr_valid), 32'd0);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gmin, gmax)) begin
                bus.ld_byte_valid = 1'b0;
                bus.ld_byte       = 8'($urandom);
                tick();
            end
            bus.ld_byte_valid = 1'b1;
            bus.ld_byte       = bytes[i];
            bus.fetch_req     = 1'($urandom_range(0, 1));
            tick();
            if ((i + 1) % 4 == 0) begin
                exp_cnt = ((i + 1) / 4 > DEPTH) ? DEPTH : (i + 1) / 4;
                chk("load.ld_count", 32'(bus.ld_count), 32'(exp_cnt));
                chk("load.fault", 32'(bus.fault), 32'd0);
            end
        end
        bus.ld_byte_valid = 1'b0;
        bus.ld_en         = 1'b0;
        bus.fetch_req     = 1'b0;
        bus.stall         = 1'b0;
        tick();
        words = n / 4;
        for (int w = 0; w < words && w < DEPTH; w++)
            ref_mem[w] = {bytes[4*w], bytes[4*w+1], bytes[4*w+2], bytes[4*w+3]};
        exp_cnt   = (words > DEPTH) ? DEPTH : words;
        exp_instr = '0;
        exp_valid = 1'b0;
        exp_fault = 1'b0;
        chk("load.exit.ld_busy", 32'(bus.ld_busy), 32'd0);
        chk("load.exit.ld_count", 32'(bus.ld_count), 32'(exp_cnt));
        chk("load.exit.ld_err", 32'(bus.ld_err), 32'((words > DEPTH) || (n % 4 != 0)));
        chk_out("load.exit");
    endtask

    initial begin
        logic [7:0]  q [$];
        logic [31:0] pc;
        int          op;

        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        bus.pc = '0; bus.fetch_req = 1'b0; bus.stall = 1'b0;
        bus.ld_en = 1'b0; bus.ld_byte = '0; bus.ld_byte_valid = 1'b0;
        reset = 1'b1;
        tick();
        do_reset();

        // Array is all NOPs before anything is loaded.
        fetch(32'd0);
        fetch(32'd4);

        q = '{8'h20, 8'h08, 8'h00, 8'h20, 8'h20, 8'h09, 8'h00, 8'h37};
        load(q, 1, 1);
        chk("dir.ld_count", 32'(bus.ld_count), 32'd2);
        chk("dir.ld_err", 32'(bus.ld_err), 32'd0);
        fetch(32'd0);
        chk("dir.word0", bus.instr, 32'h2008_0020);
        fetch(32'd4);
        chk("dir.word1", bus.instr, 32'h2009_0037);
        fetch(32'd8);

        fetch(32'h6);
        fetch(32'(DEPTH * 4));

        fetch(32'd4);
        stall_cycles(3, 32'd8);
        fetch(32'd8);

        q.delete();
        repeat (6) q.push_back(8'($urandom));
        load(q, 0, 1);
        fetch(32'd0);
        fetch(32'd4);
        q.delete();
        repeat (4) q.push_back(8'($urandom));
        load(q, 0, 0);
        fetch(32'd0);

        q.delete();
        repeat ((DEPTH + 1) * 4) q.push_back(8'($urandom));
        load(q, 0, 1);
        fetch(32'd0);
        fetch(32'((DEPTH - 1) * 4));

        // Reset after two bytes of a session: partial word dropped, counter restarts.
        bus.ld_en = 1'b1; bus.ld_byte_valid = 1'b0;
        tick();
        bus.ld_byte_valid = 1'b1; bus.ld_byte = 8'hAA; tick();
        bus.ld_byte = 8'hBB; tick();
        do_reset();
        fetch(32'd0);
        fetch(32'd4);
        fetch(32'd8);
        q = '{8'h11, 8'h22, 8'h33, 8'h44};
        load(q, 0, 0);
        fetch(32'd0);
        chk("post_reset.word0", bus.instr, 32'h1122_3344);

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op <= 4) begin
                pc = 32'($urandom_range(0, DEPTH + 1)) << 2;
                fetch(pc);
            end else if (op == 5) begin
                idle();
            end else if (op == 6) begin
                stall_cycles($urandom_range(1, 3), $urandom);
            end else if (op == 7) begin
                q.delete();
                repeat ($urandom_range(0, 14)) q.push_back(8'($urandom));
                load(q, 0, 2);
            end else if (op == 8) begin
                do_reset();
            end else begin
                fetch($urandom);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
